// File: rtl/fd_pipe_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fd_pipe_reg_pkg
//  Purpose  : Shared CPU constants: MIPS opcode/funct fields used by the
//             branch/jump predecode, fetch exception codes, reset and
//             exception vectors, and the F/D pipeline payload type.
//  Revision : 1.0 - initial release
// ============================================================================
package fd_pipe_reg_pkg;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    // SPECIAL funct field, instr[5:0]
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    // REGIMM rt field, instr[20:16]
    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;

    // Exception codes (Cause.ExcCode[6:2])
    localparam logic [4:0] EXC_NONE   = 5'd0;
    localparam logic [4:0] EXC_ADEL   = 5'd4;

    // Vectors shared by PC and CP0 logic
    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    // Contents of the fetch/decode pipeline register
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  exccode;
        logic        bd;
        logic        valid;
    } fd_payload_t;

endpackage : fd_pipe_reg_pkg
`default_nettype wire

// File: rtl/fd_pipe_reg_cti_predecode.sv
`default_nettype none
// ============================================================================
//  Module   : cti_predecode
//  Purpose  : Combinational predecode flagging control-transfer instructions
//             (beq/bne/blez/bgtz/j/jal, bltz/bgez, jr/jalr).
//  Revision : 1.0 - initial release
// ============================================================================
module cti_predecode
    import fd_pipe_reg_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic        is_cti_o
);

    logic [5:0] w_opcode;
    logic [4:0] w_rt;
    logic [5:0] w_funct;

    assign w_opcode = instr_i[31:26];
    assign w_rt     = instr_i[20:16];
    assign w_funct  = instr_i[5:0];

    // Match the opcode/rt/funct patterns of every branch and jump
    always_comb begin
        is_cti_o = 1'b0;
        case (w_opcode)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_J, OP_JAL:
                is_cti_o = 1'b1;
            OP_REGIMM:
                is_cti_o = (w_rt == RT_BLTZ) || (w_rt == RT_BGEZ);
            OP_SPECIAL:
                is_cti_o = (w_funct == FN_JR) || (w_funct == FN_JALR);
            default:
                is_cti_o = 1'b0;
        endcase
    end

endmodule : cti_predecode
`default_nettype wire

// File: rtl/fd_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : fd_pipe_reg
//  Purpose  : Fetch/decode pipeline register with stall, exception flush and
//             eret squash; derives the branch-delay-slot flag from its own
//             decode-stage predecode.
//  Revision : 1.0 - initial release
// ============================================================================
module fd_pipe_reg #(
    parameter logic [31:0] RESET_PC   = fd_pipe_reg_pkg::RESET_PC,
    parameter logic [31:0] HANDLER_PC = fd_pipe_reg_pkg::HANDLER_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        exc_flush,
    input  logic        eret_flush,
    input  logic [31:0] instr_f,
    input  logic [31:0] pc_f,
    input  logic [4:0]  exccode_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [4:0]  exccode_d,
    output logic        bd_d,
    output logic        valid_d,
    output logic        is_cti_d
);

    import fd_pipe_reg_pkg::*;

    fd_payload_t fd_q;
    fd_payload_t fd_d;
    logic        w_cti_raw;

    cti_predecode u_cti_predecode (
        .instr_i  (fd_q.instr),
        .is_cti_o (w_cti_raw)
    );

    // A bubble never counts as a branch, so it cannot mark its successor BD
    assign is_cti_d = w_cti_raw & fd_q.valid;

    // Next-state selection: exception flush > stall > eret squash > load
    always_comb begin
        fd_d = fd_q;
        if (exc_flush) begin
            fd_d.instr   = 32'h0;
            fd_d.pc      = HANDLER_PC;
            fd_d.exccode = EXC_NONE;
            fd_d.bd      = 1'b0;
            fd_d.valid   = 1'b0;
        end else if (stall) begin
            fd_d = fd_q;
        end else if (eret_flush) begin
            fd_d.instr   = 32'h0;
            fd_d.pc      = pc_f;
            fd_d.exccode = EXC_NONE;
            fd_d.bd      = 1'b0;
            fd_d.valid   = 1'b0;
        end else begin
            // A faulting fetch travels on as a nop carrying its code
            fd_d.instr   = (exccode_f == EXC_NONE) ? instr_f : 32'h0;
            fd_d.pc      = pc_f;
            fd_d.exccode = exccode_f;
            fd_d.bd      = is_cti_d;
            fd_d.valid   = 1'b1;
        end
    end

    // Pipeline register with synchronous reset to an invalid slot at RESET_PC
    always_ff @(posedge clk) begin
        if (reset) begin
            fd_q.instr   <= 32'h0;
            fd_q.pc      <= RESET_PC;
            fd_q.exccode <= EXC_NONE;
            fd_q.bd      <= 1'b0;
            fd_q.valid   <= 1'b0;
        end else begin
            fd_q <= fd_d;
        end
    end

    assign instr_d   = fd_q.instr;
    assign pc_d      = fd_q.pc;
    assign exccode_d = fd_q.exccode;
    assign bd_d      = fd_q.bd;
    assign valid_d   = fd_q.valid;

endmodule : fd_pipe_reg
`default_nettype wire

// File: tb/tb_fd_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fd_pipe_reg
//  Purpose  : Directed self-checking bench for fd_pipe_reg.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fd_pipe_reg;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        exc_flush;
    logic        eret_flush;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [4:0]  exccode_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [4:0]  exccode_d;
    logic        bd_d;
    logic        valid_d;
    logic        is_cti_d;

    int n_checks;
    int n_fail;

    fd_pipe_reg dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .exc_flush  (exc_flush),
        .eret_flush (eret_flush),
        .instr_f    (instr_f),
        .pc_f       (pc_f),
        .exccode_f  (exccode_f),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .exccode_d  (exccode_d),
        .bd_d       (bd_d),
        .valid_d    (valid_d),
        .is_cti_d   (is_cti_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic feed(input logic [31:0] pc, input logic [31:0] ins, input logic [4:0] ec);
        pc_f      = pc;
        instr_f   = ins;
        exccode_f = ec;
    endtask

    // Check every registered output plus the predecode flag
    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ins,
                           input logic [4:0] e_ec, input logic e_bd, input logic e_v,
                           input logic e_cti);
        chk({tag, ".pc"},    pc_d,                e_pc);
        chk({tag, ".instr"}, instr_d,             e_ins);
        chk({tag, ".exc"},   {27'h0, exccode_d},  {27'h0, e_ec});
        chk({tag, ".bd"},    {31'h0, bd_d},       {31'h0, e_bd});
        chk({tag, ".valid"}, {31'h0, valid_d},    {31'h0, e_v});
        chk({tag, ".cti"},   {31'h0, is_cti_d},   {31'h0, e_cti});
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        stall      = 1'b0;
        exc_flush  = 1'b0;
        eret_flush = 1'b0;
        feed(32'h0, 32'h0, 5'd0);
        tick();
        tick();
        chk_all("reset", 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Normal flow
        reset = 1'b0;
        feed(32'h3000, 32'h3C010001, 5'd0);
        tick();
        chk_all("load1", 32'h3000, 32'h3C010001, 5'd0, 1'b0, 1'b1, 1'b0);
        feed(32'h3004, 32'h00000000, 5'd0);
        tick();
        chk_all("load2", 32'h3004, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);

        // Delay slot after beq
        feed(32'h3008, 32'h10000003, 5'd0);
        tick();
        chk_all("beq", 32'h3008, 32'h10000003, 5'd0, 1'b0, 1'b1, 1'b1);
        feed(32'h300C, 32'h24020005, 5'd0);
        tick();
        chk_all("beq_ds", 32'h300C, 32'h24020005, 5'd0, 1'b1, 1'b1, 1'b0);

        // Delay slot after jr
        feed(32'h3010, 32'h03E00008, 5'd0);
        tick();
        chk_all("jr", 32'h3010, 32'h03E00008, 5'd0, 1'b0, 1'b1, 1'b1);
        feed(32'h3014, 32'h00000000, 5'd0);
        tick();
        chk_all("jr_ds", 32'h3014, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0);

        // Stall of 3 cycles holding a delay-slot instruction
        feed(32'h3018, 32'h10000003, 5'd0);
        tick();
        feed(32'h301C, 32'h24020005, 5'd0);
        tick();
        chk_all("pre_stall", 32'h301C, 32'h24020005, 5'd0, 1'b1, 1'b1, 1'b0);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            feed(32'h3020 + 32'(k * 4), 32'h3C010001, 5'd0);
            tick();
            chk_all("stall_hold", 32'h301C, 32'h24020005, 5'd0, 1'b1, 1'b1, 1'b0);
        end
        stall = 1'b0;
        feed(32'h302C, 32'h00000000, 5'd0);
        tick();
        chk_all("stall_rel", 32'h302C, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);

        // Exception flush overriding stall, with a branch in D
        feed(32'h3030, 32'h0C000000, 5'd0);
        tick();
        chk_all("jal", 32'h3030, 32'h0C000000, 5'd0, 1'b0, 1'b1, 1'b1);
        stall     = 1'b1;
        exc_flush = 1'b1;
        feed(32'h3034, 32'h24020005, 5'd0);
        tick();
        chk_all("exc_flush", 32'h4180, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        stall     = 1'b0;
        exc_flush = 1'b0;

        // Fetch fault: nop carrying AdEL
        feed(32'h5000, 32'h8C000000, 5'd4);
        tick();
        chk_all("fetch_fault", 32'h5000, 32'h0, 5'd4, 1'b0, 1'b1, 1'b0);

        // eret squash: bubble at pc_f, exception code dropped
        eret_flush = 1'b1;
        feed(32'h3010, 32'h12345678, 5'd4);
        tick();
        chk_all("eret", 32'h3010, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        eret_flush = 1'b0;

        // eret squash after a branch clears BD
        feed(32'h3048, 32'h10000003, 5'd0);
        tick();
        eret_flush = 1'b1;
        feed(32'h304C, 32'h24020005, 5'd0);
        tick();
        chk_all("eret_bd", 32'h304C, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        eret_flush = 1'b0;

        // eret with stall holds
        feed(32'h3040, 32'h24020005, 5'd0);
        tick();
        eret_flush = 1'b1;
        stall      = 1'b1;
        feed(32'h3044, 32'h3C010001, 5'd0);
        tick();
        chk_all("eret_stall", 32'h3040, 32'h24020005, 5'd0, 1'b0, 1'b1, 1'b0);
        eret_flush = 1'b0;
        stall      = 1'b0;

        // Reset mid-stream while stalled and valid
        feed(32'h3050, 32'h3C010001, 5'd0);
        tick();
        chk_all("pre_reset", 32'h3050, 32'h3C010001, 5'd0, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        stall = 1'b1;
        tick();
        chk_all("mid_reset", 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        stall = 1'b0;

        // REGIMM predecode: bgez is a branch, rt=00010 is not
        feed(32'h3054, 32'h04010002, 5'd0);
        tick();
        chk_all("bgez", 32'h3054, 32'h04010002, 5'd0, 1'b0, 1'b1, 1'b1);
        feed(32'h3058, 32'h04020002, 5'd0);
        tick();
        chk_all("regimm_other", 32'h3058, 32'h04020002, 5'd0, 1'b1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fd_pipe_reg
`default_nettype wire
